hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives enable and flush controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Resolves three hazard classes: load-use, data-memory wait and EX-stage redirect (taken branch/JAL/JALR).
//  Holds a memory-wait FSM with timeout detection and saturating performance counters.
// PARAMETERS
//  REG_W    5    register index width
//  CNT_W    32   perf counter width (saturating)
//  TO_W     8    memory-wait timer width
//  TIMEOUT  200  memory-wait cycles before mem_timeout_err (0 = disabled)
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, synchronous, active-high
//  id_rs1, id_rs2   in   REG_W  source regs of instruction in ID
//  id_rs1_used      in   1      ID instruction reads rs1
//  id_rs2_used      in   1      ID instruction reads rs2
//  idex_rd          in   REG_W  destination reg held in ID/EX
//  idex_memrd       in   1      ID/EX holds a load
//  ex_redirect      in   1      EX resolved taken branch/JAL/JALR
//  exmem_mem_req    in   1      EX/MEM instruction accesses data memory
//  mem_ready        in   1      data memory completes access this cycle
//  pc_en            out  1      PC update enable
//  pc_sel_redirect  out  1      PC loads EX target
//  ifid_en, idex_en, exmem_en  out 1 each  stage register enables
//  ifid_flush       out  1      IF/ID becomes NOP
//  idex_flush       out  1      ID/EX control bits cleared (bubble)
//  memwb_bubble     out  1      MEM/WB control bits cleared
//  mem_timeout_err  out  1      sticky: wait exceeded TIMEOUT
//  stall_cnt, flush_cnt, loaduse_cnt  out CNT_W each  perf counters
// BEHAVIOUR
//  Controls are combinational from state + inputs (same-cycle effect); state, timer, counters are registered.
//  During rst: pc_en/ifid_en/idex_en/exmem_en=0, ifid_flush=idex_flush=memwb_bubble=1, pc_sel_redirect=0;
//   next edge: state=RUN, timer=0, err=0, all counters=0.
//  Hazard terms:
//   load_use = idex_memrd & idex_rd!=0 & ((id_rs1_used & id_rs1==idex_rd) | (id_rs2_used & id_rs2==idex_rd))
//   mem_wait = exmem_mem_req & ~mem_ready
//  Priority per cycle: mem_wait > ex_redirect > load_use > normal.
//   mem_wait: all enables 0, memwb_bubble=1, no flushes; redirect/load-use deferred (their inputs are held frozen).
//   redirect: all enables 1, pc_sel_redirect=1, ifid_flush=1, idex_flush=1 (squash 2 younger instrs); load_use ignored.
//   load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; exactly one bubble.
//   normal: all enables 1, all flushes/bubble 0.
//  FSM: RUN --mem_wait--> WAIT (timer=1); WAIT --mem_ready--> RUN (timer=0); WAIT stays otherwise, timer++ (saturates at all-ones).
//   In WAIT the mem_wait priority applies while mem_ready=0; cycle with mem_ready=1 is evaluated by normal priority.
//   TIMEOUT!=0 and timer==TIMEOUT in WAIT -> mem_timeout_err set; cleared only by rst; FSM keeps waiting.
//  Counters (saturate at all-ones, never wrap):
//   stall_cnt   +1 per cycle with pc_en=0 (mem_wait or load_use).
//   flush_cnt   +1 per redirect-taken cycle.
//   loaduse_cnt +1 per load_use bubble.
//  rst mid-WAIT: immediate return to RUN, timer/err cleared, pending hazards dropped.
//  rd==0 never causes a load-use stall.
// STRUCTURE
//  Package pipe_ctrl_pkg: enum ctrl_state_e {RUN, WAIT}; struct stage_ctrl_t {en, flush} per stage.
//  One sub-module: sat_counter (parameter W; inc, rst, q), instanced for the three perf counters.
//  Rest is one FSM + combinational priority encoder.
// TESTING
//  1 load x5 in ID/EX, ID add reads rs1=x5 -> 1 cycle pc_en=0, ifid_en=0, idex_flush=1; loaduse_cnt=1, stall_cnt=1.
//  2 load x0 in ID/EX, ID reads x0 -> no stall, all enables 1, counters unchanged.
//  3 ex_redirect=1 with simultaneous load_use -> pc_sel_redirect=1, ifid_flush=idex_flush=1, no stall; flush_cnt=1, loaduse_cnt=0.
//  4 exmem_mem_req=1, mem_ready low 3 cycles then high -> enables 0 + memwb_bubble=1 for 3 cycles, state WAIT, stall_cnt=3, then RUN.
//  5 TIMEOUT=4, mem_ready held low 10 cycles -> mem_timeout_err rises in 4th WAIT cycle, stays 1; rst clears it and returns RUN.
//  6 CNT_W=4, 20 load_use bubbles -> loaduse_cnt saturates at 15, no wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types for the pipeline stall/flush sequencer:
//                sequencer state, per-cycle hazard decision, and the
//                per-stage {en, flush} control pair with its common values.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Memory-wait sequencer state.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_e;

  // Winning hazard class for the current cycle, after priority resolution.
  typedef enum logic [1:0] {
    HZ_NORMAL   = 2'd0,
    HZ_LOADUSE  = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_MEMWAIT  = 2'd3
  } hz_mode_e;

  // Control pair for one pipeline register: write enable and clear-to-NOP.
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t c_STAGE_RUN    = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t c_STAGE_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t c_STAGE_SQUASH = '{en: 1'b1, flush: 1'b1};
  localparam stage_ctrl_t c_STAGE_RESET  = '{en: 1'b0, flush: 1'b1};

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at all-ones instead of
//                wrapping. Synchronous active-high reset to zero.
//  Ports       : clk  in   clock
//                rst  in   synchronous reset, active-high
//                inc  in   count enable (one step per cycle)
//                q    out  W  current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Resolves data-memory wait, EX redirect and load-use hazards
//                (in that priority), tracks memory waits with a timeout
//                detector, and keeps saturating performance counters.
//  Ports       : clk, rst                         clock, sync active-high reset
//                id_rs1, id_rs2, id_rs*_used      ID-stage source operands
//                idex_rd, idex_memrd              ID/EX destination / is-load
//                ex_redirect                      EX taken branch/JAL/JALR
//                exmem_mem_req, mem_ready         data-memory handshake
//                pc_en, pc_sel_redirect           PC control
//                ifid_en/flush, idex_en/flush     stage register controls
//                exmem_en, memwb_bubble           stage register controls
//                mem_timeout_err                  sticky memory-wait timeout
//                stall_cnt, flush_cnt, loaduse_cnt  saturating perf counters
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_memrd,
  input  logic             ex_redirect,
  input  logic             exmem_mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] loaduse_cnt
);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_nxt;
  logic [TO_W-1:0] r_timer;
  logic [TO_W-1:0] w_timer_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic            w_load_use;
  logic            w_mem_wait;
  logic            w_to_hit;
  hz_mode_e        w_mode;

  // The PC reuses the stage pair: flush means "load the EX redirect target".
  stage_ctrl_t     w_pc;
  stage_ctrl_t     w_ifid;
  stage_ctrl_t     w_idex;
  logic            w_exmem_en;
  logic            w_memwb_bubble;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign w_load_use = idex_memrd && (idex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == idex_rd)) ||
                       (id_rs2_used && (id_rs2 == idex_rd)));

  // While in WAIT the EX/MEM request is frozen by the stall itself, so only
  // mem_ready decides whether this cycle is still a wait cycle.
  assign w_mem_wait = (r_state == WAIT) ? !mem_ready
                                        : (exmem_mem_req && !mem_ready);

  // Timeout flag is visible in the very cycle the timer reaches TIMEOUT and
  // is held by r_err from the following cycle on.
  assign w_to_hit = (TIMEOUT != 0) && (r_state == WAIT) &&
                    (32'(r_timer) == TIMEOUT);

  always_comb begin
    w_mode = HZ_NORMAL;
    if (w_mem_wait) begin
      w_mode = HZ_MEMWAIT;
    end else if (ex_redirect) begin
      w_mode = HZ_REDIRECT;
    end else if (w_load_use) begin
      w_mode = HZ_LOADUSE;
    end
  end

  // --------------------------------------------------------------------------
  // Stage controls (combinational, same-cycle effect)
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc           = c_STAGE_RUN;
    w_ifid         = c_STAGE_RUN;
    w_idex         = c_STAGE_RUN;
    w_exmem_en     = 1'b1;
    w_memwb_bubble = 1'b0;
    if (rst) begin
      w_pc           = c_STAGE_HOLD;
      w_ifid         = c_STAGE_RESET;
      w_idex         = c_STAGE_RESET;
      w_exmem_en     = 1'b0;
      w_memwb_bubble = 1'b1;
    end else begin
      case (w_mode)
        HZ_MEMWAIT: begin
          // Freeze everything; MEM/WB receives a bubble while EX/MEM waits.
          w_pc           = c_STAGE_HOLD;
          w_ifid         = c_STAGE_HOLD;
          w_idex         = c_STAGE_HOLD;
          w_exmem_en     = 1'b0;
          w_memwb_bubble = 1'b1;
        end
        HZ_REDIRECT: begin
          // Load target, squash the two younger instructions in IF/ID, ID/EX.
          w_pc   = c_STAGE_SQUASH;
          w_ifid = c_STAGE_SQUASH;
          w_idex = c_STAGE_SQUASH;
        end
        HZ_LOADUSE: begin
          // Hold PC and IF/ID, insert one bubble into ID/EX; the load
          // advances to MEM so the next cycle can forward its data.
          w_pc   = c_STAGE_HOLD;
          w_ifid = c_STAGE_HOLD;
          w_idex = c_STAGE_SQUASH;
        end
        default: begin
          w_pc = c_STAGE_RUN;
        end
      endcase
    end
  end

  assign pc_en           = w_pc.en;
  assign pc_sel_redirect = w_pc.flush;
  assign ifid_en         = w_ifid.en;
  assign ifid_flush      = w_ifid.flush;
  assign idex_en         = w_idex.en;
  assign idex_flush      = w_idex.flush;
  assign exmem_en        = w_exmem_en;
  assign memwb_bubble    = w_memwb_bubble;
  assign mem_timeout_err = r_err || w_to_hit;

  // --------------------------------------------------------------------------
  // Memory-wait FSM with timer and sticky timeout error
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err || w_to_hit;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          w_state_nxt = WAIT;
          w_timer_nxt = TO_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          w_state_nxt = RUN;
          w_timer_nxt = '0;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + TO_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((w_mode == HZ_MEMWAIT) || (w_mode == HZ_LOADUSE)),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_mode == HZ_REDIRECT),
    .q   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_mode == HZ_LOADUSE),
    .q   (loaduse_cnt)
  );

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed scoreboard bench for hazard_stall_ctrl. A driver
//                applies one vector per cycle and queues its hand-computed
//                expectation; a monitor pops and compares each cycle.
//                DUT built with CNT_W=4 and TIMEOUT=4 so saturation and
//                timeout are reachable quickly.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  // Control vector order:
  // {pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
  //  exmem_en, memwb_bubble}
  localparam logic [7:0] c_NORM = 8'b1010_1010;
  localparam logic [7:0] c_RST  = 8'b0001_0101;
  localparam logic [7:0] c_LU   = 8'b0000_1110;
  localparam logic [7:0] c_RED  = 8'b1111_1110;
  localparam logic [7:0] c_MW   = 8'b0000_0001;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_rs1_used, id_rs2_used, idex_memrd;
  logic       ex_redirect, exmem_mem_req, mem_ready;
  logic       pc_en, pc_sel_redirect, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, memwb_bubble, mem_timeout_err;
  logic [3:0] stall_cnt, flush_cnt, loaduse_cnt;

  hazard_stall_ctrl #(
    .REG_W   (5),
    .CNT_W   (4),
    .TO_W    (8),
    .TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .idex_rd         (idex_rd),
    .idex_memrd      (idex_memrd),
    .ex_redirect     (ex_redirect),
    .exmem_mem_req   (exmem_mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .pc_sel_redirect (pc_sel_redirect),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .loaduse_cnt     (loaduse_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      nm;
    logic [7:0] ctrl;
    logic       chk;   // also compare err and counters
    logic       err;
    int         s;
    int         f;
    int         l;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // --------------------------------------------------------------------------
  // Monitor: compare on the falling edge, away from the active edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = q_exp.pop_front();
      act = {pc_en, pc_sel_redirect, ifid_en, ifid_flush,
             idex_en, idex_flush, exmem_en, memwb_bubble};
      n_tests++;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b expected %b", e.nm, act, e.ctrl);
      end
      if (e.chk) begin
        n_tests++;
        if (mem_timeout_err !== e.err) begin
          n_fail++;
          $display("FAIL %s err: got %b expected %b", e.nm, mem_timeout_err, e.err);
        end
        n_tests++;
        if ({1'b0, stall_cnt} !== 5'(e.s) || {1'b0, flush_cnt} !== 5'(e.f) ||
            {1'b0, loaduse_cnt} !== 5'(e.l)) begin
          n_fail++;
          $display("FAIL %s cnt: got s=%0d f=%0d l=%0d expected s=%0d f=%0d l=%0d",
                   e.nm, stall_cnt, flush_cnt, loaduse_cnt, e.s, e.f, e.l);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver: one vector per cycle, applied 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic vec(input string nm, input logic r,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic ld,
                     input logic red, input logic req, input logic rdy,
                     input logic [7:0] ec, input logic chk, input logic eerr,
                     input int es, input int ef, input int el);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    id_rs1        = rs1;
    id_rs1_used   = u1;
    id_rs2        = rs2;
    id_rs2_used   = u2;
    idex_rd       = rd;
    idex_memrd    = ld;
    ex_redirect   = red;
    exmem_mem_req = req;
    mem_ready     = rdy;
    e.nm   = nm;
    e.ctrl = ec;
    e.chk  = chk;
    e.err  = eerr;
    e.s    = es;
    e.f    = ef;
    e.l    = el;
    q_exp.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; idex_memrd = 1'b0;
    ex_redirect = 1'b0; exmem_mem_req = 1'b0; mem_ready = 1'b0;

    // Reset: controls forced, then counters/err cleared after first edge.
    vec("rst0", 1, 0,0, 0,0, 0,0, 0,0,0, c_RST, 0,0, 0,0,0);
    vec("rst1", 1, 0,0, 0,0, 0,0, 0,0,0, c_RST, 1,0, 0,0,0);

    // Load x5 in ID/EX, ID reads x5 via rs1: one bubble.
    vec("lu_rs1",   0, 5,1, 0,0, 5,1, 0,0,0, c_LU,   1,0, 0,0,0);
    vec("lu_after", 0, 5,1, 0,0, 5,0, 0,0,0, c_NORM, 1,0, 1,0,1);
    // Load to x0 never stalls.
    vec("x0_load",  0, 0,1, 0,1, 0,1, 0,0,0, c_NORM, 1,0, 1,0,1);
    vec("idle0",    0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 1,0,1);
    // Matching rs1 not used -> no stall; matching rs2 used -> stall.
    vec("rs1_unused", 0, 7,0, 3,1, 7,1, 0,0,0, c_NORM, 1,0, 1,0,1);
    vec("lu_rs2",     0, 2,1, 7,1, 7,1, 0,0,0, c_LU,   1,0, 1,0,1);
    vec("idle1",      0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 2,0,2);

    // Redirect with simultaneous load-use: redirect wins.
    vec("rst2",     1, 0,0, 0,0, 0,0, 0,0,0, c_RST,  1,0, 2,0,2);
    vec("red_lu",   0, 5,1, 0,0, 5,1, 1,0,0, c_RED,  1,0, 0,0,0);
    vec("red_after",0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 0,1,0);

    // Memory wait: ready low 3 cycles, then high, then back in RUN.
    vec("mw0",      0, 0,0, 0,0, 0,0, 0,1,0, c_MW,   1,0, 0,1,0);
    vec("mw1",      0, 0,0, 0,0, 0,0, 0,1,0, c_MW,   1,0, 1,1,0);
    vec("mw2",      0, 0,0, 0,0, 0,0, 0,1,0, c_MW,   1,0, 2,1,0);
    vec("mw_done",  0, 0,0, 0,0, 0,0, 0,1,1, c_NORM, 1,0, 3,1,0);
    vec("mw_run",   0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 3,1,0);

    // Timeout: ready low 10 cycles with a pending redirect held frozen.
    // Error appears in the 4th cycle spent in WAIT (i==4) and sticks.
    for (int i = 0; i < 10; i++) begin
      vec($sformatf("to%0d", i), 0, 0,0, 0,0, 0,0, 1,1,0, c_MW,
          1, (i >= 4), 3 + i, 1, 0);
    end
    vec("to_rst",   1, 0,0, 0,0, 0,0, 1,1,0, c_RST,  0,0, 0,0,0);
    vec("to_clear", 0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 0,0,0);

    // Saturation: 20 load-use cycles with 4-bit counters stop at 15.
    for (int i = 0; i < 20; i++) begin
      vec($sformatf("sat%0d", i), 0, 9,1, 0,0, 9,1, 0,0,0, c_LU,
          1, 0, (i > 15) ? 15 : i, 0, (i > 15) ? 15 : i);
    end
    vec("sat_end",  0, 0,0, 0,0, 0,0, 0,0,0, c_NORM, 1,0, 15,0,15);

    @(negedge clk);
    #1;
    for (int k = 0; k < 5 && q_exp.size() != 0; k++) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
